// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_t;

  // odd = 0 gives even parity (total ones including the parity bit is even).
  function automatic logic uart_parity(input logic [DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out port bundle of the UART transmitter.
// Handshake: i_Tx_DV is the valid; the implicit ready is "transmitter in IDLE".
// A byte transfers on an edge where both hold; valid elsewhere is dropped.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Active;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and strobes o_Bit_End on the last count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Bit_End
);

  localparam int         W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign o_Bit_End = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter, 8N1, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert a parity bit (sense PARITY_ODD) before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  uart_tx_if.slave    tx,
  output uart_state_t o_State
);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic       PAR_SENSE = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [2:0]           bit_idx, idx_n;
  logic                 serial, serial_n;
  logic                 active, active_n;
  logic                 done, done_n;
  logic                 bit_end;
  logic                 baud_clear;
  logic                 parity_bit;

  // Holding the counter clear while idle makes the accepting edge count 0.
  assign baud_clear = (state == IDLE) || (state == CLEANUP);
  assign parity_bit = uart_parity(shift_reg, PAR_SENSE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (baud_clear),
    .o_Bit_End(bit_end)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      serial    <= LINE_IDLE;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_idx   <= idx_n;
      serial    <= serial_n;
      active    <= active_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tx.i_Tx_DV) state_n = START;
      START:   if (bit_end) state_n = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:    if (bit_end && (bit_idx == LAST_IDX)) state_n = PARITY;
      PARITY:  if (bit_end) state_n = STOP;
`else
      DATA:    if (bit_end && (bit_idx == LAST_IDX)) state_n = STOP;
`endif
      STOP:    if (bit_end) state_n = CLEANUP;
      CLEANUP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the output registers, so the line changes on the same
  // edge as the state transition that selects the new bit.
  always_comb begin
    shift_n  = shift_reg;
    idx_n    = bit_idx;
    serial_n = serial;
    active_n = active;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        serial_n = LINE_IDLE;
        active_n = 1'b0;
        idx_n    = '0;
        if (tx.i_Tx_DV) begin
          shift_n  = tx.i_Tx_Byte;
          serial_n = 1'b0;
          active_n = 1'b1;
        end
      end
      START: begin
        if (bit_end) serial_n = shift_reg[0];
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            serial_n = PAR_EN ? parity_bit : LINE_IDLE;
          end else begin
            idx_n    = bit_idx + 3'd1;
            serial_n = shift_reg[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) serial_n = LINE_IDLE;
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_n   = 1'b1;
          active_n = 1'b0;
        end
      end
      CLEANUP: begin
        serial_n = LINE_IDLE;
        active_n = 1'b0;
      end
      default: begin
        serial_n = LINE_IDLE;
        active_n = 1'b0;
      end
    endcase
  end

  assign tx.o_Tx_Serial = serial;
  assign tx.o_Tx_Active = active;
  assign tx.o_Tx_Done   = done;
  assign o_State        = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame-slot model, line decoder scoreboard and
// literal pins on hand-worked frames. Honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB     = 4;
  localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB         = 11;
  localparam int EXP_FRAMES = 23;
`else
  localparam int NB         = 10;
  localparam int EXP_FRAMES = 22;
`endif
  localparam int FRAME_CYC = NB * CPB;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_state_t dbg_state;
  uart_tx_if   bus();

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PAR_ODD)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .tx     (bus),
    .o_State(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame as a list of line slots, each CPB cycles long.
  int          m_k = -1;
  logic        m_frame [NB];
  logic [7:0]  exp_q [$];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_k >= 0 && m_k < (NB - 1) * CPB + CPB / 2 && exp_q.size() > 0)
        void'(exp_q.pop_back());
      m_k = -1;
    end else if ((m_k < 0 || m_k >= FRAME_CYC + 1) && bus.i_Tx_DV === 1'b1) begin
      m_k = 0;
      m_frame[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_frame[i + 1] = bus.i_Tx_Byte[i];
      if (NB == 11) m_frame[9] = logic'((($countones(bus.i_Tx_Byte) % 2) ^ PAR_ODD) != 0);
      m_frame[NB - 1] = 1'b1;
      exp_q.push_back(bus.i_Tx_Byte);
    end else if (m_k >= 0 && m_k <= FRAME_CYC + 1) begin
      m_k++;
    end
  end

  // Per-cycle compare against the model
  logic e_s, e_a, e_d;
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_k >= 0 && m_k < FRAME_CYC) begin
        e_s = m_frame[m_k / CPB]; e_a = 1'b1; e_d = 1'b0;
      end else if (m_k == FRAME_CYC) begin
        e_s = 1'b1; e_a = 1'b0; e_d = 1'b1;
      end else begin
        e_s = 1'b1; e_a = 1'b0; e_d = 1'b0;
      end
      check("cyc_serial", bus.o_Tx_Serial, e_s);
      check("cyc_active", bus.o_Tx_Active, e_a);
      check("cyc_done",   bus.o_Tx_Done,   e_d);
    end
  end

  // Scoreboard: mid-bit line decoder popping exp_q
  int         dec_t = -1;
  int         dec_frames = 0;
  int         done_cnt = 0;
  logic [7:0] dec_b;
  logic [7:0] dec_exp;
  logic       dec_start, dec_par;
  int         slot;

  always @(negedge clk) begin
    if (chk_en && bus.o_Tx_Done === 1'b1) done_cnt++;
    if (rst) begin
      dec_t = -1;
    end else if (chk_en) begin
      if (dec_t < 0) begin
        if (bus.o_Tx_Serial === 1'b0) dec_t = 0;
      end else begin
        dec_t++;
      end
      if (dec_t >= 0 && (dec_t % CPB) == CPB / 2) begin
        slot = dec_t / CPB;
        if (slot == 0) dec_start = bus.o_Tx_Serial;
        else if (slot <= 8) dec_b[slot - 1] = bus.o_Tx_Serial;
        else if (slot < NB - 1) dec_par = bus.o_Tx_Serial;
        if (slot == NB - 1) begin
          dec_frames++;
          check("frame_start", dec_start, 1'b0);
          check("frame_stop", bus.o_Tx_Serial, 1'b1);
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            dec_exp = exp_q.pop_front();
            check("frame_byte", dec_b, dec_exp);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", dec_par, (($countones(dec_exp) % 2) ^ PAR_ODD) != 0);
`endif
          end
          dec_t = -1;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    bus.i_Tx_Byte = b;
    bus.i_Tx_DV   = 1'b1;
    @(negedge clk);
    bus.i_Tx_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [9:0]  pat10;
  logic [10:0] pat11;
  int          saved_done;

  initial begin
    bus.i_Tx_DV   = 1'b0;
    bus.i_Tx_Byte = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    // byte valid during reset must be dropped
    bus.i_Tx_Byte = 8'hEE;
    bus.i_Tx_DV   = 1'b1;
    @(negedge clk);
    bus.i_Tx_DV   = 1'b0;
    check("rst_serial", bus.o_Tx_Serial, 1'b1);
    check("rst_active", bus.o_Tx_Active, 1'b0);
    check("rst_done",   bus.o_Tx_Done,   1'b0);
    check("rst_state",  dbg_state,       IDLE);
    rst = 1'b0;
    idle(3);
    check("rst_dv_dropped", bus.o_Tx_Active, 1'b0);

`ifndef UART_TX_PARITY_EN
    // 0x55 pinned by hand: slots 0,1,0,1,0,1,0,1,0,1, done at E0+40
    pat10 = 10'b1010101010;
    send(8'h55);
    for (int k = 0; k < 42; k++) begin
      if (k < 40) begin
        check("p55_serial", bus.o_Tx_Serial, pat10[k / 4]);
        check("p55_active", bus.o_Tx_Active, 1'b1);
      end else begin
        check("p55_done",   bus.o_Tx_Done, (k == 40) ? 1'b1 : 1'b0);
        check("p55_active_end", bus.o_Tx_Active, 1'b0);
      end
      @(negedge clk);
    end
`else
    send(8'h55);
    idle(FRAME_CYC + 2);
`endif

    // 0x00 then 0xFF then 0x12 at minimum spacing
    send(8'h00);
    idle(FRAME_CYC);
    check("gap_serial0", bus.o_Tx_Serial, 1'b1);
    idle(1);
    check("gap_serial1", bus.o_Tx_Serial, 1'b1);
    send(8'hFF);
    check("ff_start", bus.o_Tx_Serial, 1'b0);
    idle(4);
    check("ff_bit0", bus.o_Tx_Serial, 1'b1);
    idle(FRAME_CYC - 3);
    send(8'h12);
    check("b2b_accept", bus.o_Tx_Active, 1'b1);

    // valid during final stop edge and CLEANUP must be ignored
    idle(FRAME_CYC - 1);
    bus.i_Tx_Byte = 8'h99;
    bus.i_Tx_DV   = 1'b1;
    idle(2);
    bus.i_Tx_DV   = 1'b0;
    idle(FRAME_CYC + 10);
    check("cleanup_dv_ignored", bus.o_Tx_Active, 1'b0);
    check("idle_state", dbg_state, IDLE);

    // 0x3C with a stray 0xA3 valid during DATA, byte input changed afterwards
    send(8'h3C);
    idle(9);
    bus.i_Tx_Byte = 8'hA3;
    bus.i_Tx_DV   = 1'b1;
    idle(1);
    bus.i_Tx_DV   = 1'b0;
    idle(FRAME_CYC + 20);

    // reset during data bit 3 of 0x81
    saved_done = done_cnt;
    send(8'h81);
    idle(17);
    rst = 1'b1;
    idle(1);
    check("midrst_serial", bus.o_Tx_Serial, 1'b1);
    check("midrst_active", bus.o_Tx_Active, 1'b0);
    rst = 1'b0;
    idle(FRAME_CYC + 5);
    check("midrst_no_done", done_cnt, saved_done);
    send(8'h5A);
    check("post_rst_accept", bus.o_Tx_Active, 1'b1);
    idle(FRAME_CYC + 1);

    // random bytes at or near minimum spacing
    for (int n = 0; n < 16; n++) begin
      send(8'($urandom_range(0, 255)));
      idle(FRAME_CYC + 1 + $urandom_range(0, 3));
    end

`ifdef UART_TX_PARITY_EN
    // 0x07, even parity: slots 0,1,1,1,0,0,0,0,0,1,1 and done at E0+44
    pat11 = 11'b11000001110;
    send(8'h07);
    for (int k = 0; k < 46; k++) begin
      if (k < 44) check("p07_serial", bus.o_Tx_Serial, pat11[k / 4]);
      if (k == 37) check("p07_parity_bit", bus.o_Tx_Serial, 1'b1);
      if (k >= 44) check("p07_done", bus.o_Tx_Done, (k == 44) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
`endif

    idle(FRAME_CYC + 5);
    check("total_done_pulses", done_cnt, EXP_FRAMES);
    check("total_frames_decoded", dec_frames, EXP_FRAMES);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
